// File: rtl/bk_pipe_accum.sv
// Two-stage pipelined Brent-Kung adder with accumulator, saturation and valid/ready on both sides.
// Define BK_PIPE_ACCUM_APPROX_EN to make the low APPROX_BITS a lower-part OR adder.
module bk_pipe_accum #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4,
  parameter int SAT         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [WIDTH-1:0] acc_q
);
  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // the producer holds valid and data stable until that edge.

`ifdef BK_PIPE_ACCUM_APPROX_EN
  localparam bit USE_APPROX = 1'b1;
`else
  localparam bit USE_APPROX = 1'b0;
`endif
  localparam int AB  = USE_APPROX ? APPROX_BITS : 0;
  localparam int LOG = $clog2(WIDTH);

  logic             r_s1_valid;
  logic             r_s1_acc;
  logic [WIDTH-1:0] r_s1_pv;
  logic [WIDTH-1:0] r_s1_gp;
  logic [WIDTH-1:0] r_s1_gg;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic [WIDTH-1:0] r_acc;

  logic             w_out_free;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic             w_load_out;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_pv;
  logic [WIDTH-1:0] w_up_p;
  logic [WIDTH-1:0] w_up_g;
  logic [WIDTH-1:0] w_dn_g;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum_raw;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_out_free;
  // An accumulate beat in S1 blocks intake so the next beat never sees a stale acc_q.
  assign in_ready   = w_s1_adv && !(r_s1_valid && r_s1_acc);
  assign w_in_fire  = in_valid && in_ready;
  assign w_load_out = r_s1_valid && w_out_free;

  // S1: operand select, bitwise p/g and up-sweep. Approximate low bits feed the tree
  // with p=0 so only the carry a&b of the top approximate bit enters the upper part.
  always_comb begin
    logic [WIDTH-1:0] w_tp;
    logic [WIDTH-1:0] w_tg;
    w_b_eff = in_acc ? (acc_clr ? '0 : r_acc) : in_b;
    w_pv    = '0;
    w_tp    = '0;
    w_tg    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < AB) begin
        w_pv[i] = in_a[i] | w_b_eff[i];
        if (i == AB - 1) w_tg[i] = in_a[i] & w_b_eff[i];
      end else begin
        w_pv[i] = in_a[i] ^ w_b_eff[i];
        w_tp[i] = in_a[i] ^ w_b_eff[i];
        w_tg[i] = in_a[i] & w_b_eff[i];
      end
    end
    for (int l = 0; l < LOG; l++) begin
      for (int i = (1 << (l + 1)) - 1; i < WIDTH; i += (1 << (l + 1))) begin
        w_tg[i] = w_tg[i] | (w_tp[i] & w_tg[i - (1 << l)]);
        w_tp[i] = w_tp[i] & w_tp[i - (1 << l)];
      end
    end
    w_up_p = w_tp;
    w_up_g = w_tg;
  end

  // S2: down-sweep completes every prefix carry, then sum and saturation.
  always_comb begin
    logic [WIDTH-1:0] w_tg;
    w_tg = r_s1_gg;
    for (int l = LOG - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (1 << (l + 1))) begin
        w_tg[i] = w_tg[i] | (r_s1_gp[i] & w_tg[i - (1 << l)]);
      end
    end
    w_dn_g = w_tg;
  end

  assign w_c    = {w_dn_g[WIDTH-2:0], 1'b0};
  assign w_cout = w_dn_g[WIDTH-1];

  always_comb begin
    w_sum_raw = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum_raw[i] = (i < AB) ? r_s1_pv[i] : (r_s1_pv[i] ^ w_c[i]);
    end
    w_sum = ((SAT != 0) && w_cout) ? '1 : w_sum_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_acc   <= 1'b0;
      r_s1_pv    <= '0;
      r_s1_gp    <= '0;
      r_s1_gg    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_acc <= in_acc;
        r_s1_pv  <= w_pv;
        r_s1_gp  <= w_up_p;
        r_s1_gg  <= w_up_g;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_cout  <= w_cout;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Clear wins over a simultaneous accumulate load; the loaded result is still emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_load_out && r_s1_acc) begin
      r_acc <= w_sum;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign acc_q     = r_acc;

endmodule

// File: tb/tb_bk_pipe_accum.sv
// Directed bench for bk_pipe_accum: latency, overflow/saturation, accumulate hazard,
// backpressure, reset flush, bypass clear and streamed adds at 8 and 32 bits.
module tb_bk_pipe_accum;

`ifdef BK_PIPE_ACCUM_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif
  localparam int AB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_acc = 1'b0, acc_clr = 1'b0, out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, out_cout;
  logic [15:0] out_sum, acc_q;
  logic        sat_in_ready, sat_out_valid, sat_out_cout;
  logic [15:0] sat_out_sum, sat_acc_q;

  logic        v_valid = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        w8_in_ready, w8_out_valid, w8_out_cout;
  logic [7:0]  w8_out_sum, w8_acc_q;
  logic        w32_in_ready, w32_out_valid, w32_out_cout;
  logic [31:0] w32_out_sum, w32_acc_q;

  bk_pipe_accum #(.WIDTH(16), .APPROX_BITS(AB), .SAT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .acc_q(acc_q));

  bk_pipe_accum #(.WIDTH(16), .APPROX_BITS(AB), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_sum(sat_out_sum),
    .out_cout(sat_out_cout), .acc_q(sat_acc_q));

  bk_pipe_accum #(.WIDTH(8), .APPROX_BITS(AB), .SAT(0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_valid), .in_ready(w8_in_ready),
    .in_a(a8), .in_b(b8), .in_acc(1'b0), .acc_clr(1'b0),
    .out_valid(w8_out_valid), .out_ready(1'b1), .out_sum(w8_out_sum),
    .out_cout(w8_out_cout), .acc_q(w8_acc_q));

  bk_pipe_accum #(.WIDTH(32), .APPROX_BITS(AB), .SAT(0)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_valid), .in_ready(w32_in_ready),
    .in_a(a32), .in_b(b32), .in_acc(1'b0), .acc_clr(1'b0),
    .out_valid(w32_out_valid), .out_ready(1'b1), .out_sum(w32_out_sum),
    .out_cout(w32_out_cout), .acc_q(w32_acc_q));

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] rx_q[$];
  logic [63:0] exp8_q[$];
  logic [63:0] exp32_q[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) rx_q.push_back({out_cout, out_sum});
  end

  // Reference: {cout,sum} as a (w+1)-bit value.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] up, low;
    logic        cin;
    if (!APPROX) return a + b;
    low = (a | b) & ((64'h1 << AB) - 64'h1);
    cin = a[AB-1] & b[AB-1];
    up  = (a >> AB) + (b >> AB) + {63'b0, cin};
    return (up << AB) | low;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called and returning at posedge+1
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic acc,
                      input logic clr);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_acc = acc; acc_clr = clr;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) break;
    end
    in_valid = 1'b0; in_acc = 1'b0; acc_clr = 1'b0;
    chk("accept", {63'b0, ok}, 64'd1);
  endtask

  task automatic drain_check(input string tag);
    for (int k = 0; k < 20 && rx_q.size() < exp_q.size(); k++) step();
    chk({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && rx_q.size() > 0) chk(tag, 64'(rx_q.pop_front()), 64'(exp_q.pop_front()));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hl_sum, ov_sum, ov_sat_sum;
    logic        ov_cout;
    if (APPROX) begin
      hl_sum = 16'h222F; ov_sum = 16'hFFFF; ov_sat_sum = 16'hFFFF; ov_cout = 1'b0;
    end else begin
      hl_sum = 16'h2233; ov_sum = 16'h0000; ov_sat_sum = 16'hFFFF; ov_cout = 1'b1;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_cout", {63'b0, out_cout}, 64'd0);
    chk("rst_acc_q", 64'(acc_q), 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    rst_n = 1'b1;
    step();

    // headline add and two-edge latency
    out_ready = 1'b1;
    send(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_early", {63'b0, out_valid}, 64'd0);
    step();
    @(negedge clk);
    chk("lat_valid", {63'b0, out_valid}, 64'd1);
    chk("hl_sum", 64'(out_sum), 64'(hl_sum));
    chk("hl_cout", {63'b0, out_cout}, 64'd0);
    chk("hl_sat_sum", 64'(sat_out_sum), 64'(hl_sum));
    exp_q.push_back({1'b0, hl_sum});
    step();

    // overflow, unsaturated and saturated
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    step();
    @(negedge clk);
    chk("ov_sum", 64'(out_sum), 64'(ov_sum));
    chk("ov_cout", {63'b0, out_cout}, {63'b0, ov_cout});
    chk("ov_sat_sum", 64'(sat_out_sum), 64'(ov_sat_sum));
    chk("ov_sat_cout", {63'b0, sat_out_cout}, {63'b0, ov_cout});
    exp_q.push_back({ov_cout, ov_sum});
    step();
    drain_check("basic");

    // accumulate: clear, then three back-to-back accumulate beats
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    @(negedge clk);
    chk("clr_acc_q", 64'(acc_q), 64'd0);
    step();
    in_valid = 1'b1; in_acc = 1'b1; in_a = 16'h0100; in_b = 16'hABCD;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("acc_ready", {63'b0, in_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
      step();
      if (k == 4) begin in_valid = 1'b0; in_acc = 1'b0; end
    end
    exp_q.push_back(17'h00100);
    exp_q.push_back(17'h00200);
    exp_q.push_back(17'h00300);
    repeat (3) step();
    chk("acc_final", 64'(acc_q), 64'h0300);
    drain_check("acc");

    // reset with both stages full
    out_ready = 1'b0;
    send(16'h0005, 16'h0005, 1'b0, 1'b0);
    send(16'h0006, 16'h0006, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_out_valid", {63'b0, out_valid}, 64'd1);
    chk("full_in_ready", {63'b0, in_ready}, 64'd0);
    chk("full_acc_q", 64'(acc_q), 64'h0300);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_acc_q", 64'(acc_q), 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    chk("no_out_after_rst", 64'(rx_q.size()), 64'd0);

    // backpressure: two beats held, third waits, drain-and-refill
    out_ready = 1'b0;
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    send(16'h0002, 16'h0002, 1'b0, 1'b0);
    in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0003;
    @(negedge clk);
    chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    chk("bp_out_sum", 64'(out_sum), 64'(16'(model(64'd1, 64'd1))));
    step();
    @(negedge clk);
    chk("bp_hold", {63'b0, in_ready}, 64'd0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_refill", {63'b0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    exp_q.push_back(17'(model(64'd1, 64'd1)));
    exp_q.push_back(17'(model(64'd2, 64'd2)));
    exp_q.push_back(17'(model(64'd3, 64'd3)));
    drain_check("bp");

    // clear concurrent with accumulate accept uses a zero operand
    send(16'h0050, 16'h1111, 1'b1, 1'b1);
    exp_q.push_back(17'h00050);
    repeat (3) step();
    chk("bypass_acc_q", 64'(acc_q), 64'h0050);
    drain_check("bypass");

    // streamed random adds at 8 and 32 bits, one per cycle
    for (int k = 0; k < 204; k++) begin
      if (k < 200) begin
        a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
        a32 = $urandom; b32 = $urandom;
        v_valid = 1'b1;
        exp8_q.push_back(model(64'(a8), 64'(b8)));
        exp32_q.push_back(model(64'(a32), 64'(b32)));
      end else begin
        v_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 200) chk("w8_ready", {63'b0, w8_in_ready}, 64'd1);
      if (w8_out_valid) begin
        if (exp8_q.size() == 0) chk("w8_extra", 64'd1, 64'd0);
        else chk("w8_sum", 64'({w8_out_cout, w8_out_sum}), exp8_q.pop_front());
      end
      if (w32_out_valid) begin
        if (exp32_q.size() == 0) chk("w32_extra", 64'd1, 64'd0);
        else chk("w32_sum", 64'({w32_out_cout, w32_out_sum}), exp32_q.pop_front());
      end
      step();
    end
    chk("w8_left", 64'(exp8_q.size()), 64'd0);
    chk("w32_left", 64'(exp32_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
